// File: rtl/decode_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage_pkg : shared ALU-facing types for the decode stage  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package decode_stage_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int INSTR_W    = 32;

   typedef enum logic [6:0] {
      F7_NORMAL = 7'b0000000,
      F7_ALT    = 7'b0100000
   } alu_funct7_e;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SRL  = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } alu_funct3_e;

   typedef enum logic [6:0] {
      OP     = 7'b0110011,
      OP_IMM = 7'b0010011
   } opcode_e;

endpackage
`default_nettype wire

// File: rtl/decode_stage_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage_regfile : 2R1W register file, x0 hardwired to zero  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module decode_stage_regfile
   import decode_stage_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic                  clk_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic [DATA_W-1:0]     rs1_data_o,
   output logic [DATA_W-1:0]     rs2_data_o,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i
);

   localparam int IDX_W = $clog2(REG_COUNT);

   logic [DATA_W-1:0] mem_q [REG_COUNT];
   logic              wr_ok;

   function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
      return (a != '0) && (32'(a) < 32'(REG_COUNT));
   endfunction

   // A same-cycle write is forwarded so the reader never sees a stale value.
   function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (in_range(a)) begin
         if (we_i && (waddr_i == a)) v = wdata_i;
         else                        v = mem_q[a[IDX_W-1:0]];
      end
      return v;
   endfunction

   assign wr_ok = we_i && in_range(waddr_i);

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
   end

   always_comb begin
      rs1_data_o = read_port(rs1_addr_i);
      rs2_data_o = read_port(rs2_addr_i);
   end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage : RV32I OP/OP-IMM decode and operand fetch for ALU  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [INSTR_W-1:0]    instr_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic                  wb_en_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [DATA_W-1:0]     wb_data_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_W-1:0]     operand_1_o,
   output logic [DATA_W-1:0]     operand_2_o,
   output alu_funct7_e           funct7_o,
   output alu_funct3_e           funct3_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic                  rd_we_o,
   output logic                  illegal_o
);

   logic [6:0]            opcode;
   logic [REG_ADDR_W-1:0] rd, rs1, rs2;
   logic [2:0]            f3;
   logic [6:0]            f7;
   logic [DATA_W-1:0]     imm, rs1_data, rs2_data;
   logic                  legal, alt, use_rs2, accept;

   logic                  ex_valid_q,   ex_valid_d;
   logic [DATA_W-1:0]     operand_1_q,  operand_1_d;
   logic [DATA_W-1:0]     operand_2_q,  operand_2_d;
   alu_funct7_e           funct7_q,     funct7_d;
   alu_funct3_e           funct3_q,     funct3_d;
   logic [REG_ADDR_W-1:0] rd_q,         rd_d;
   logic                  rd_we_q,      rd_we_d;
   logic                  illegal_q,    illegal_d;

   assign opcode = instr_i[6:0];
   assign rd     = instr_i[11:7];
   assign f3     = instr_i[14:12];
   assign rs1    = instr_i[19:15];
   assign rs2    = instr_i[24:20];
   assign f7     = instr_i[31:25];
   assign imm    = {{(DATA_W-12){instr_i[31]}}, instr_i[31:20]};

   decode_stage_regfile #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
   ) u_regfile (
      .clk_i      (clk_i),
      .rs1_addr_i (rs1),
      .rs2_addr_i (rs2),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data),
      .we_i       (wb_en_i),
      .waddr_i    (wb_rd_i),
      .wdata_i    (wb_data_i)
   );

   always_comb begin
      legal   = 1'b0;
      alt     = 1'b0;
      use_rs2 = 1'b0;
      if (opcode == OP) begin
         use_rs2 = 1'b1;
         if (f7 == F7_NORMAL) begin
            legal = 1'b1;
         end else if ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL))) begin
            legal = 1'b1;
            alt   = 1'b1;
         end
      end else if (opcode == OP_IMM) begin
         // imm[11:5] doubles as funct7 only for the shift-immediate forms.
         if (f3 == F3_SLL) begin
            legal = (f7 == F7_NORMAL);
         end else if (f3 == F3_SRL) begin
            legal = (f7 == F7_NORMAL) || (f7 == F7_ALT);
            alt   = (f7 == F7_ALT);
         end else begin
            legal = 1'b1;
         end
      end
      if ((REG_COUNT == 16) && (rs1[4] || rd[4] || (use_rs2 && rs2[4]))) legal = 1'b0;
   end

   always_comb begin
      operand_1_d = '0;
      operand_2_d = '0;
      funct7_d    = F7_NORMAL;
      funct3_d    = F3_ADD;
      rd_d        = '0;
      rd_we_d     = 1'b0;
      illegal_d   = !legal;
      ex_valid_d  = 1'b1;
      if (legal) begin
         operand_1_d = rs1_data;
         operand_2_d = use_rs2 ? rs2_data : imm;
         funct7_d    = alt ? F7_ALT : F7_NORMAL;
         funct3_d    = alu_funct3_e'(f3);
         rd_d        = rd;
         rd_we_d     = (rd != '0);
      end
   end

   assign instr_ready_o = !flush_i && (!ex_valid_q || ex_ready_i);
   assign accept        = instr_valid_i && instr_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         ex_valid_q  <= 1'b0;
         operand_1_q <= '0;
         operand_2_q <= '0;
         funct7_q    <= F7_NORMAL;
         funct3_q    <= F3_ADD;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (accept) begin
         ex_valid_q  <= ex_valid_d;
         operand_1_q <= operand_1_d;
         operand_2_q <= operand_2_d;
         funct7_q    <= funct7_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         illegal_q   <= illegal_d;
      end else if (ex_ready_i) begin
         ex_valid_q  <= 1'b0;
      end
   end

   assign ex_valid_o  = ex_valid_q;
   assign operand_1_o = operand_1_q;
   assign operand_2_o = operand_2_q;
   assign funct7_o    = funct7_q;
   assign funct3_o    = funct3_q;
   assign rd_o        = rd_q;
   assign rd_we_o     = rd_we_q;
   assign illegal_o   = illegal_q;

endmodule
`default_nettype wire
